rv_mem_stage: RTL
=================

# rv_mem_stage

Memory stage of the RV32I pipeline. It takes the EX/MEM pipeline registers, runs load/store transactions on a req/ack data bus with arbitrary wait states, and aligns and extends load data. While a transaction is pending it stalls the upstream stages. It drives the MEM/WB pipeline registers and the MEM-stage forwarding value back to EX.

## Interface
- Parameters: none. Data width is fixed at `XLEN = 32.
- i_mem_clk  in  1  clock, rising edge.
- i_mem_rstn  in  1  asynchronous, active-low reset.
- i_mem_is_load  in  1  load instruction in MEM.
- i_mem_dmem_we  in  1  store instruction in MEM.
- i_mem_dmem_bytectrl  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- i_mem_alu_res  in  32  effective address, or ALU result.
- i_mem_ext_imm  in  32  immediate, used by LUI.
- i_mem_pc_plus_4  in  32  link value.
- i_mem_dmem_wd  in  32  store data, unaligned (taken from bits [7:0] / [15:0] / [31:0]).
- i_mem_rf_we  in  1  register-file write enable.
- i_mem_rf_wa  in  5  destination register.
- i_mem_rf_wd_pre_sel  in  2  00 alu_res, 01 ext_imm, 10 pc_plus_4, 11 alu_res.
- o_mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- o_mem_rf_rd_fwd  out  32  pre-selected non-load value, forwarded to EX.
- o_mem_dbus_req  out  1  bus request.
- o_mem_dbus_we  out  1  1 = write.
- o_mem_dbus_addr  out  32  {alu_res[31:2], 2'b00}.
- o_mem_dbus_be  out  4  byte enables.
- o_mem_dbus_wdata  out  32  lane-replicated store data.
- i_mem_dbus_ack  in  1  transaction complete. Read data is valid in the same cycle.
- i_mem_dbus_rdata  in  32  read word.
- o_mem_wb_rf_we  out  1  MEM/WB register-file write enable.
- o_mem_wb_rf_wa  out  5  MEM/WB destination register.
- o_mem_wb_rf_wd  out  32  MEM/WB final write-back data.
- o_mem_wb_misalign  out  1  misaligned access retired this cycle; pulse, registered.

## Operation
- access = is_load | dmem_we.
- A misaligned access is an access with one of:
  - H/HU and alu_res[0] = 1
  - W and alu_res[1:0] != 0
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0]
  - H/HU: addr[1] ? 4'b1100 : 4'b0011
  - W: 4'b1111
- Write data:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- Load extraction:
  - Shift rdata right by 8·addr[1:0].
  - Take [7:0] or [15:0].
  - Sign-extend for B/H; zero-extend for BU/HU.
  - W passes rdata unchanged.
- FSM states: IDLE, WAIT.
  - IDLE, aligned access, no ack: o_mem_dbus_req = 1, go to WAIT.
  - IDLE, aligned access, ack in the same cycle: zero-wait completion; stay in IDLE.
  - WAIT: hold req = 1 until ack, then return to IDLE.
- o_mem_stall = aligned access & ~i_mem_dbus_ack, in either state.
- Bus outputs are combinational from the EX/MEM inputs. Stability during WAIT is guaranteed by the stall.
- A misaligned access never asserts req and never stalls. It retires in one cycle with o_mem_wb_rf_we = 0 and o_mem_wb_misalign = 1. The store is suppressed.
- Write-back data:
  - is_load: the extended load data.
  - otherwise: the pre_sel mux output.
- o_mem_rf_rd_fwd is always the pre_sel mux output. It is never load data: load-use hazards are stalled by the hazard unit.
- Bubble: access = 0 and rf_we = 0. It passes through as a MEM/WB bubble.

## Timing
- Reset is asynchronous. It forces state = IDLE and clears all MEM/WB outputs to 0 immediately.
  - A req held in WAIT drops with reset. Any later ack is ignored.
- MEM/WB update on each rising edge:
  - Stalled: rf_we = 0, misalign = 0 (bubble). rf_wa and rf_wd may hold.
  - Otherwise: capture rf_we, rf_wa, the final write data and the misalign flag.
- Latency:
  - Non-access instruction: 1 cycle to MEM/WB.
  - Zero-wait access: 1 cycle.
  - Access with N wait cycles: stall for N cycles, retire on cycle N+1.
- An ack in IDLE without an access is ignored.
- Back-to-back accesses:
  - A new access may start in the cycle after the previous ack. The FSM is in IDLE by then.
  - No idle cycle is required between accesses.
- Ack in WAIT and reset asserted in the same cycle: reset wins and nothing is written.

## Test plan
- Reset mid-transaction: LW issued, reset asserted during WAIT -> req, stall and o_mem_wb_rf_we fall to 0 in the same cycle. State is IDLE after release.
- LW x5 from 0x100 with ack held low 3 cycles, rdata = 0xDEADBEEF -> req = 1 and stall = 1 for 3 cycles, be = 4'b1111. On the next edge: wb_rf_we = 1, wa = 5, wd = 0xDEADBEEF.
- Byte/half loads, zero-wait ack, rdata = 0x8001_7F80:
  - LB at 0x203 -> wd = 0xFFFFFF80.
  - LBU at 0x203 -> wd = 0x00000080.
  - LH at 0x202 -> wd = 0xFFFF8001.
  - LHU at 0x200 -> wd = 0x00007F80.
- SB wd = 0x12345678 at 0x301 -> addr = 0x300, be = 4'b0010, wdata = 0x78787878, we = 1. wb_rf_we = 0.
- Misaligned accesses:
  - SW at 0x402 -> no req, no stall, o_mem_wb_misalign = 1 for one cycle.
  - LH at 0x401 -> same response, plus wb_rf_we = 0.
- JAL-style write-back: pre_sel = 10, pc_plus_4 = 0x1004 -> o_mem_rf_rd_fwd = 0x1004 in the same cycle, then wb wd = 0x1004.
- Back-to-back: LW then SW, each acked with zero wait -> 2 consecutive retires, no stall cycles.

Source files
------------

// File: rtl/rv_mem_stage_if.sv
// Data-bus bundle between the MEM stage (master) and data memory (slave).
// The request side is a req/ack handshake; read data is valid with ack.
interface rv_mem_stage_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      input  dbus_ack, dbus_rdata
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      output dbus_ack, dbus_rdata
   );
endinterface

// File: rtl/rv_mem_stage.sv
// RV32I memory stage: runs loads/stores on a req/ack bus with wait states,
// aligns and extends load data, stalls upstream while a transfer is pending.
module rv_mem_stage (
   input  logic        i_mem_clk,
   input  logic        i_mem_rstn,
   input  logic        i_mem_is_load,
   input  logic        i_mem_dmem_we,
   input  logic [2:0]  i_mem_dmem_bytectrl,
   input  logic [31:0] i_mem_alu_res,
   input  logic [31:0] i_mem_ext_imm,
   input  logic [31:0] i_mem_pc_plus_4,
   input  logic [31:0] i_mem_dmem_wd,
   input  logic        i_mem_rf_we,
   input  logic [4:0]  i_mem_rf_wa,
   input  logic [1:0]  i_mem_rf_wd_pre_sel,
   output logic        o_mem_stall,
   output logic [31:0] o_mem_rf_rd_fwd,
   rv_mem_stage_if.master dbus,
   output logic        o_mem_wb_rf_we,
   output logic [4:0]  o_mem_wb_rf_wa,
   output logic [31:0] o_mem_wb_rf_wd,
   output logic        o_mem_wb_misalign
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state_q;
   logic        access_p0;
   logic        is_b_p0;
   logic        is_h_p0;
   logic        misalign_p0;
   logic        aligned_p0;
   logic        stall_p0;
   logic [31:0] pre_val_p0;
   logic [31:0] wd_final_p0;

   function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                               input logic [1:0]  ofs,
                                               input logic [31:0] rdata);
      logic [31:0]        sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] sx;
      sh = rdata >> {ofs, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      case (f3)
         3'b000:  begin sx = b; load_extend = sx; end
         3'b001:  begin sx = h; load_extend = sx; end
         3'b100:  load_extend = {24'd0, sh[7:0]};
         3'b101:  load_extend = {16'd0, sh[15:0]};
         default: load_extend = rdata;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic is_b, input logic is_h,
                                               input logic [1:0] ofs);
      if (is_b)
         byte_enables = 4'b0001 << ofs;
      else if (is_h)
         byte_enables = ofs[1] ? 4'b1100 : 4'b0011;
      else
         byte_enables = 4'b1111;
   endfunction

   function automatic logic [31:0] store_lanes(input logic is_b, input logic is_h,
                                               input logic [31:0] wd);
      if (is_b)
         store_lanes = {4{wd[7:0]}};
      else if (is_h)
         store_lanes = {2{wd[15:0]}};
      else
         store_lanes = wd;
   endfunction

   // Stage p0: decode, alignment check and combinational bus drive
   always_comb begin
      is_b_p0 = 1'b0;
      is_h_p0 = 1'b0;
      case (i_mem_dmem_bytectrl)
         3'b000, 3'b100: is_b_p0 = 1'b1;
         3'b001, 3'b101: is_h_p0 = 1'b1;
         default:        ;
      endcase
   end

   assign access_p0   = i_mem_is_load | i_mem_dmem_we;
   assign misalign_p0 = access_p0 &
                        ((is_h_p0 & i_mem_alu_res[0]) |
                         (~is_b_p0 & ~is_h_p0 & (i_mem_alu_res[1:0] != 2'b00)));
   assign aligned_p0  = access_p0 & ~misalign_p0;
   assign stall_p0    = aligned_p0 & ~dbus.dbus_ack;

   // Reset gates the handshake outputs so an in-flight request drops at once.
   assign o_mem_stall     = stall_p0 & i_mem_rstn;
   assign dbus.dbus_req   = aligned_p0 & i_mem_rstn;
   assign dbus.dbus_we    = i_mem_dmem_we & aligned_p0 & i_mem_rstn;
   assign dbus.dbus_addr  = {i_mem_alu_res[31:2], 2'b00};
   assign dbus.dbus_be    = byte_enables(is_b_p0, is_h_p0, i_mem_alu_res[1:0]);
   assign dbus.dbus_wdata = store_lanes(is_b_p0, is_h_p0, i_mem_dmem_wd);

   always_comb begin
      case (i_mem_rf_wd_pre_sel)
         2'b01:   pre_val_p0 = i_mem_ext_imm;
         2'b10:   pre_val_p0 = i_mem_pc_plus_4;
         default: pre_val_p0 = i_mem_alu_res;
      endcase
   end

   assign o_mem_rf_rd_fwd = pre_val_p0;
   assign wd_final_p0     = i_mem_is_load
                          ? load_extend(i_mem_dmem_bytectrl, i_mem_alu_res[1:0], dbus.dbus_rdata)
                          : pre_val_p0;

   always_ff @(posedge i_mem_clk or negedge i_mem_rstn) begin
      if (!i_mem_rstn) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (aligned_p0 && !dbus.dbus_ack) state_q <= WAIT;
            WAIT:    if (dbus.dbus_ack)                state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stage p1: MEM/WB register; a stalled cycle retires as a bubble
   always_ff @(posedge i_mem_clk or negedge i_mem_rstn) begin
      if (!i_mem_rstn) begin
         o_mem_wb_rf_we    <= 1'b0;
         o_mem_wb_rf_wa    <= 5'd0;
         o_mem_wb_rf_wd    <= 32'd0;
         o_mem_wb_misalign <= 1'b0;
      end else if (stall_p0) begin
         o_mem_wb_rf_we    <= 1'b0;
         o_mem_wb_misalign <= 1'b0;
      end else begin
         o_mem_wb_rf_we    <= i_mem_rf_we & ~misalign_p0;
         o_mem_wb_rf_wa    <= i_mem_rf_wa;
         o_mem_wb_rf_wd    <= wd_final_p0;
         o_mem_wb_misalign <= misalign_p0;
      end
   end

endmodule
